life_gen_scheduler: RTL and testbench

- Sequences the Game-of-Life grid engine: decides when a generation step happens and when a seed is loaded.
- Handles run/pause, single-step and re-seed from debounced user buttons.
- Paces generations against a per-frame tick and counts generations.
- Auto-halts on extinction or a still life. Sits between the button/display timing logic and the grid engine.

---
 rtl/life_gen_scheduler.sv | 213 +++++++++++++++++++++
 tb/tb_life_gen_scheduler.sv | 431 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/life_gen_scheduler.sv
// Game-of-Life generation scheduler: turns debounced button levels and the
// per-frame tick into step_en / seed_load pulses for the grid engine,
// counts generations and halts on extinction or a still life.
module life_gen_scheduler #(
    parameter int unsigned WIDTH  = 20,
    parameter int unsigned HEIGHT = 15,
    parameter int unsigned GEN_W  = 16,
    parameter int unsigned SPD_W  = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      frame_tick,
    input  logic                      btn_run,
    input  logic                      btn_step,
    input  logic                      btn_seed,
    input  logic [SPD_W-1:0]          speed,
    input  logic                      auto_halt,
    input  logic [HEIGHT*WIDTH-1:0]   grid,
    output logic                      step_en,
    output logic                      seed_load,
    output logic                      running,
    output logic                      halted,
    output logic                      extinct,
    output logic [GEN_W-1:0]          gen_count
);

    // S_STEP is the cycle in which step_en is high; S_CHECK follows it with
    // the engine's freshly computed grid on the input.
    typedef enum logic [2:0] {
        S_PAUSED,
        S_RUN,
        S_STEP,
        S_CHECK,
        S_HALT
    } state_t;

    state_t                    state;
    state_t                    state_n;
    logic                      ret_run;
    logic                      ret_run_n;
    logic                      pend_step;
    logic                      pend_step_n;
    logic                      pend_run;
    logic                      pend_run_n;
    logic [SPD_W-1:0]          frame_cnt;
    logic [SPD_W-1:0]          frame_cnt_n;
    logic                      step_en_n;
    logic                      seed_load_n;
    logic [GEN_W-1:0]          gen_n;
    logic                      extinct_n;

    logic                      run_q;
    logic                      step_q;
    logic                      seed_q;
    logic                      armed;
    logic [HEIGHT*WIDTH-1:0]   prev_grid;

    logic                      run_edge;
    logic                      step_edge;
    logic                      seed_edge;
    logic                      step_req;
    logic                      run_req;
    logic                      grid_zero;
    logic                      grid_stable;

    // armed stays low for the first clock after reset so that a button held
    // through reset does not look like a fresh press when reset releases.
    assign run_edge  = armed & btn_run  & ~run_q;
    assign step_edge = armed & btn_step & ~step_q;
    assign seed_edge = armed & btn_seed & ~seed_q;

    // Edges that arrived during STEP/CHECK are replayed from the pending flags.
    assign step_req = step_edge | pend_step;
    assign run_req  = run_edge  | pend_run;

    assign grid_zero   = (grid == '0);
    assign grid_stable = (grid == prev_grid);

    assign running = (state == S_RUN) ||
                     (((state == S_STEP) || (state == S_CHECK)) && ret_run);
    assign halted  = (state == S_HALT);

    // Previous button levels for rising-edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run_q  <= 1'b0;
            step_q <= 1'b0;
            seed_q <= 1'b0;
            armed  <= 1'b0;
        end else begin
            run_q  <= btn_run;
            step_q <= btn_step;
            seed_q <= btn_seed;
            armed  <= 1'b1;
        end
    end

    // Snapshot of the pre-step grid for still-life detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_grid <= '0;
        end else if (step_en) begin
            prev_grid <= grid;
        end
    end

    // Scheduler state and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_PAUSED;
            ret_run   <= 1'b0;
            pend_step <= 1'b0;
            pend_run  <= 1'b0;
            frame_cnt <= '0;
            step_en   <= 1'b0;
            seed_load <= 1'b0;
            gen_count <= '0;
            extinct   <= 1'b0;
        end else begin
            state     <= state_n;
            ret_run   <= ret_run_n;
            pend_step <= pend_step_n;
            pend_run  <= pend_run_n;
            frame_cnt <= frame_cnt_n;
            step_en   <= step_en_n;
            seed_load <= seed_load_n;
            gen_count <= gen_n;
            extinct   <= extinct_n;
        end
    end

    // Next-state and next-output logic; seed outranks step, step outranks run.
    always_comb begin
        state_n     = state;
        ret_run_n   = ret_run;
        pend_step_n = pend_step;
        pend_run_n  = pend_run;
        frame_cnt_n = frame_cnt;
        step_en_n   = 1'b0;
        seed_load_n = 1'b0;
        gen_n       = step_en ? gen_count + GEN_W'(1) : gen_count;
        extinct_n   = extinct;

        if (seed_edge) begin
            seed_load_n = 1'b1;
            state_n     = S_PAUSED;
            ret_run_n   = 1'b0;
            pend_step_n = 1'b0;
            pend_run_n  = 1'b0;
            frame_cnt_n = '0;
            gen_n       = '0;
            extinct_n   = 1'b0;
        end else begin
            case (state)
                S_PAUSED: begin
                    pend_step_n = 1'b0;
                    pend_run_n  = 1'b0;
                    if (step_req) begin
                        step_en_n = 1'b1;
                        ret_run_n = 1'b0;
                        state_n   = S_STEP;
                    end else if (run_req) begin
                        frame_cnt_n = '0;
                        state_n     = S_RUN;
                    end
                end
                S_RUN: begin
                    pend_step_n = 1'b0;
                    pend_run_n  = 1'b0;
                    if (run_req) begin
                        state_n = S_PAUSED;
                    end else if (frame_tick) begin
                        // >= rather than == so a speed lowered mid-run
                        // cannot make the counter run past it.
                        if (frame_cnt >= speed) begin
                            step_en_n   = 1'b1;
                            frame_cnt_n = '0;
                            ret_run_n   = 1'b1;
                            state_n     = S_STEP;
                        end else begin
                            frame_cnt_n = frame_cnt + SPD_W'(1);
                        end
                    end
                end
                S_STEP: begin
                    pend_step_n = pend_step | step_edge;
                    pend_run_n  = pend_run  | run_edge;
                    state_n     = S_CHECK;
                end
                S_CHECK: begin
                    extinct_n = grid_zero;
                    if (auto_halt && (grid_zero || grid_stable)) begin
                        pend_step_n = 1'b0;
                        pend_run_n  = 1'b0;
                        state_n     = S_HALT;
                    end else begin
                        pend_step_n = pend_step | step_edge;
                        pend_run_n  = pend_run  | run_edge;
                        state_n     = ret_run ? S_RUN : S_PAUSED;
                    end
                end
                S_HALT: begin
                    pend_step_n = 1'b0;
                    pend_run_n  = 1'b0;
                end
                default: begin
                    state_n = S_PAUSED;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_life_gen_scheduler.sv
// Bench for life_gen_scheduler: a Game-of-Life engine model reacts to the
// scheduler's pulses; expectations come from tick arithmetic and life rules.
module tb_life_gen_scheduler;

    localparam int unsigned W = 20;
    localparam int unsigned H = 15;
    localparam int unsigned N = W * H;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         frame_tick = 1'b0;
    logic         btn_run = 1'b0;
    logic         btn_step = 1'b0;
    logic         btn_seed = 1'b0;
    logic [3:0]   speed = 4'd0;
    logic         auto_halt = 1'b0;
    logic [N-1:0] grid;
    logic [N-1:0] seed_pat;
    logic [N-1:0] pat_blinker;
    logic [N-1:0] pat_block;
    logic [N-1:0] pat_single;

    logic         step_en, seed_load, running, halted, extinct;
    logic [15:0]  gen_count;
    logic         s4_step_en, s4_seed_load, s4_running, s4_halted, s4_extinct;
    logic [3:0]   gen4;

    int unsigned  checks = 0;
    int unsigned  errors = 0;
    int unsigned  exp_gen = 0;
    int unsigned  n_steps = 0;
    int unsigned  cyc = 0;
    int unsigned  last_step = 0;
    int unsigned  spacing_viol = 0;
    int unsigned  overlap = 0;
    int unsigned  mism4 = 0;

    life_gen_scheduler #(.WIDTH(W), .HEIGHT(H), .GEN_W(16), .SPD_W(4)) dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick),
        .btn_run(btn_run), .btn_step(btn_step), .btn_seed(btn_seed),
        .speed(speed), .auto_halt(auto_halt), .grid(grid),
        .step_en(step_en), .seed_load(seed_load), .running(running),
        .halted(halted), .extinct(extinct), .gen_count(gen_count)
    );

    life_gen_scheduler #(.WIDTH(W), .HEIGHT(H), .GEN_W(4), .SPD_W(4)) dut4 (
        .clk(clk), .reset(reset), .frame_tick(frame_tick),
        .btn_run(btn_run), .btn_step(btn_step), .btn_seed(btn_seed),
        .speed(speed), .auto_halt(auto_halt), .grid(grid),
        .step_en(s4_step_en), .seed_load(s4_seed_load), .running(s4_running),
        .halted(s4_halted), .extinct(s4_extinct), .gen_count(gen4)
    );

    always #5 clk = ~clk;

    // Conway's rules on a bounded grid (cells outside are dead).
    function automatic logic [N-1:0] life_next(input logic [N-1:0] g);
        logic [N-1:0] nx;
        int n;
        nx = '0;
        for (int r = 0; r < int'(H); r++) begin
            for (int c = 0; c < int'(W); c++) begin
                n = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        if ((dr != 0 || dc != 0) && r + dr >= 0 && r + dr < int'(H) &&
                            c + dc >= 0 && c + dc < int'(W)) begin
                            if (g[(r + dr) * int'(W) + c + dc]) n++;
                        end
                    end
                end
                if (g[r * int'(W) + c]) nx[r * int'(W) + c] = (n == 2 || n == 3);
                else                    nx[r * int'(W) + c] = (n == 3);
            end
        end
        return nx;
    endfunction

    // Engine model: loads the seed or advances one generation on the pulses.
    always @(posedge clk or negedge reset) begin
        if (!reset)         grid <= seed_pat;
        else if (seed_load) grid <= seed_pat;
        else if (step_en)   grid <= life_next(grid);
    end

    // Pulse bookkeeping and cross-check of the 4-bit-counter instance.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (step_en) begin
            n_steps <= n_steps + 1;
            if (last_step != 0 && cyc - last_step < 2) spacing_viol <= spacing_viol + 1;
            last_step <= cyc;
        end
        if (step_en && seed_load) overlap <= overlap + 1;
        if ({s4_step_en, s4_seed_load, s4_running, s4_halted, s4_extinct, gen4} !==
            {step_en, seed_load, running, halted, extinct, gen_count[3:0]})
            mism4 <= mism4 + 1;
    end

    task automatic press(input logic r, input logic s, input logic sd);
        btn_run = r; btn_step = s; btn_seed = sd;
        @(negedge clk);
        btn_run = 1'b0; btn_step = 1'b0; btn_seed = 1'b0;
    endtask

    task automatic do_tick(input int unsigned gap, output logic se);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        se = step_en;
        repeat (gap) @(negedge clk);
    endtask

    task automatic test_reset;
        int unsigned s0;
        logic se;
        repeat (3) @(negedge clk);
        checks++;
        if ({step_en, seed_load, running, halted, extinct, gen_count} !== 21'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected all zero",
                     {step_en, seed_load, running, halted, extinct, gen_count});
        end
        reset = 1'b1;
        @(negedge clk);
        s0 = n_steps;
        for (int i = 0; i < 10; i++) do_tick(2, se);
        @(negedge clk);
        checks++;
        if (n_steps - s0 !== 0) begin errors++; $display("FAIL idle_steps: got %0d expected 0", n_steps - s0); end
        checks++;
        if (gen_count !== 16'd0) begin errors++; $display("FAIL idle_gen: got %0d expected 0", gen_count); end
        checks++;
        if (running !== 1'b0 || halted !== 1'b0) begin
            errors++; $display("FAIL idle_flags: running=%b halted=%b expected 0 0", running, halted);
        end
    endtask

    task automatic test_single_step;
        int unsigned s0;
        s0 = n_steps;
        btn_step = 1'b1;
        @(negedge clk);
        checks++;
        if (step_en !== 1'b1) begin errors++; $display("FAIL step_pulse1: got %b expected 1", step_en); end
        btn_step = 1'b0;
        @(negedge clk);
        checks++;
        if (gen_count !== 16'd1) begin errors++; $display("FAIL step_gen1: got %0d expected 1", gen_count); end
        btn_step = 1'b1;  // edge lands while the scheduler is in CHECK
        @(negedge clk);
        btn_step = 1'b0;
        @(negedge clk);
        checks++;
        if (step_en !== 1'b1) begin errors++; $display("FAIL step_pending: got %b expected 1", step_en); end
        repeat (3) @(negedge clk);
        exp_gen = 2;
        checks++;
        if (gen_count !== 16'(exp_gen)) begin errors++; $display("FAIL step_gen2: got %0d expected %0d", gen_count, exp_gen); end
        checks++;
        if (n_steps - s0 !== 2) begin errors++; $display("FAIL step_count: got %0d expected 2", n_steps - s0); end
        checks++;
        if (running !== 1'b0) begin errors++; $display("FAIL step_running: got %b expected 0", running); end
    endtask

    task automatic test_run_pacing;
        int unsigned spd, nt, s0, expected;
        logic se, exp_se;
        for (int t = 0; t < 4; t++) begin
            spd = (t == 0) ? 2 : $urandom_range(0, 3);
            nt  = (t == 0) ? 9 : $urandom_range(4, 12);
            speed = 4'(spd);
            s0 = n_steps;
            expected = 0;
            press(1'b1, 1'b0, 1'b0);
            checks++;
            if (running !== 1'b1) begin errors++; $display("FAIL run_start: running=%b expected 1", running); end
            for (int k = 1; k <= int'(nt); k++) begin
                frame_tick = 1'b1;
                @(negedge clk);
                frame_tick = 1'b0;
                se = step_en;
                exp_se = ((k % (int'(spd) + 1)) == 0);
                if (exp_se) expected++;
                checks++;
                if (se !== exp_se) begin
                    errors++; $display("FAIL run_tick spd=%0d tick=%0d: step_en=%b expected %b", spd, k, se, exp_se);
                end
                btn_step = 1'($urandom_range(0, 1));  // step presses must be ignored while running
                @(negedge clk);
                btn_step = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
            press(1'b1, 1'b0, 1'b0);
            repeat (2) @(negedge clk);
            exp_gen += expected;
            checks++;
            if (running !== 1'b0) begin errors++; $display("FAIL run_pause: running=%b expected 0", running); end
            checks++;
            if (gen_count !== 16'(exp_gen)) begin errors++; $display("FAIL run_gen: got %0d expected %0d", gen_count, exp_gen); end
            checks++;
            if (n_steps - s0 !== expected) begin errors++; $display("FAIL run_steps: got %0d expected %0d", n_steps - s0, expected); end
        end
    endtask

    task automatic test_still_life;
        int unsigned s0;
        logic se;
        seed_pat = pat_block;
        press(1'b0, 1'b0, 1'b1);
        exp_gen = 0;
        checks++;
        if (seed_load !== 1'b1 || gen_count !== 16'd0) begin
            errors++; $display("FAIL still_seed: seed_load=%b gen=%0d expected 1 0", seed_load, gen_count);
        end
        @(negedge clk);
        checks++;
        if (seed_load !== 1'b0) begin errors++; $display("FAIL still_seed_once: got %b expected 0", seed_load); end
        auto_halt = 1'b1;
        speed = 4'd0;
        press(1'b1, 1'b0, 1'b0);
        s0 = n_steps;
        do_tick(0, se);
        checks++;
        if (se !== 1'b1) begin errors++; $display("FAIL still_step: got %b expected 1", se); end
        @(negedge clk);
        checks++;
        if (halted !== 1'b0 || running !== 1'b1) begin
            errors++; $display("FAIL still_check: halted=%b running=%b expected 0 1", halted, running);
        end
        @(negedge clk);
        exp_gen = 1;
        checks++;
        if (halted !== 1'b1 || running !== 1'b0 || extinct !== 1'b0) begin
            errors++; $display("FAIL still_halt: halted=%b running=%b extinct=%b expected 1 0 0", halted, running, extinct);
        end
        checks++;
        if (gen_count !== 16'(exp_gen)) begin errors++; $display("FAIL still_gen: got %0d expected %0d", gen_count, exp_gen); end
        auto_halt = 1'b0;
        for (int i = 0; i < 3; i++) do_tick(2, se);
        press(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        press(1'b0, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        checks++;
        if (n_steps - s0 !== 1 || halted !== 1'b1) begin
            errors++; $display("FAIL halt_sticky: steps=%0d halted=%b expected 1 1", n_steps - s0, halted);
        end
        seed_pat = pat_blinker;
        press(1'b0, 1'b0, 1'b1);
        exp_gen = 0;
        checks++;
        if (seed_load !== 1'b1 || halted !== 1'b0 || gen_count !== 16'd0 || running !== 1'b0) begin
            errors++; $display("FAIL halt_exit: seed_load=%b halted=%b gen=%0d running=%b expected 1 0 0 0",
                               seed_load, halted, gen_count, running);
        end
        @(negedge clk);
    endtask

    task automatic test_extinction;
        logic se;
        auto_halt = 1'b0;
        speed = 4'd0;
        seed_pat = pat_single;
        press(1'b0, 1'b0, 1'b1);
        exp_gen = 0;
        @(negedge clk);
        press(1'b1, 1'b0, 1'b0);
        do_tick(2, se);
        checks++;
        if (extinct !== 1'b1 || running !== 1'b1 || halted !== 1'b0) begin
            errors++; $display("FAIL extinct_run: extinct=%b running=%b halted=%b expected 1 1 0", extinct, running, halted);
        end
        do_tick(2, se);
        checks++;
        if (se !== 1'b1) begin errors++; $display("FAIL extinct_continue: step_en=%b expected 1", se); end
        press(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        exp_gen = 2;
        checks++;
        if (gen_count !== 16'(exp_gen)) begin errors++; $display("FAIL extinct_gen: got %0d expected %0d", gen_count, exp_gen); end
        auto_halt = 1'b1;
        press(1'b0, 1'b0, 1'b1);
        exp_gen = 0;
        @(negedge clk);
        press(1'b1, 1'b0, 1'b0);
        do_tick(2, se);
        exp_gen = 1;
        checks++;
        if (halted !== 1'b1 || extinct !== 1'b1 || running !== 1'b0) begin
            errors++; $display("FAIL extinct_halt: halted=%b extinct=%b running=%b expected 1 1 0", halted, extinct, running);
        end
        seed_pat = pat_blinker;
        press(1'b0, 1'b0, 1'b1);
        exp_gen = 0;
        checks++;
        if (extinct !== 1'b0 || halted !== 1'b0) begin
            errors++; $display("FAIL extinct_clear: extinct=%b halted=%b expected 0 0", extinct, halted);
        end
        auto_halt = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_simultaneous;
        int unsigned s0;
        s0 = n_steps;
        press(1'b0, 1'b1, 1'b1);
        checks++;
        if (seed_load !== 1'b1 || step_en !== 1'b0) begin
            errors++; $display("FAIL seed_step: seed_load=%b step_en=%b expected 1 0", seed_load, step_en);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (n_steps - s0 !== 0 || gen_count !== 16'd0) begin
            errors++; $display("FAIL seed_step_after: steps=%0d gen=%0d expected 0 0", n_steps - s0, gen_count);
        end
        press(1'b1, 1'b1, 1'b0);
        checks++;
        if (step_en !== 1'b1) begin errors++; $display("FAIL step_over_run: step_en=%b expected 1", step_en); end
        repeat (4) @(negedge clk);
        exp_gen = 1;
        checks++;
        if (running !== 1'b0 || n_steps - s0 !== 1 || gen_count !== 16'(exp_gen)) begin
            errors++; $display("FAIL step_over_run_after: running=%b steps=%0d gen=%0d expected 0 1 %0d",
                               running, n_steps - s0, gen_count, exp_gen);
        end
    endtask

    task automatic test_wrap;
        logic se;
        press(1'b0, 1'b0, 1'b1);
        exp_gen = 0;
        @(negedge clk);
        speed = 4'd0;
        press(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 15; i++) do_tick(2, se);
        exp_gen = 15;
        checks++;
        if (gen4 !== 4'(exp_gen) || gen_count !== 16'(exp_gen)) begin
            errors++; $display("FAIL wrap_15: gen4=%0d gen16=%0d expected 15 15", gen4, gen_count);
        end
        do_tick(2, se);
        exp_gen = 16;
        checks++;
        if (gen4 !== 4'(exp_gen) || gen_count !== 16'(exp_gen)) begin
            errors++; $display("FAIL wrap_16: gen4=%0d gen16=%0d expected 0 16", gen4, gen_count);
        end
        do_tick(2, se);
        exp_gen = 17;
        checks++;
        if (gen4 !== 4'(exp_gen)) begin errors++; $display("FAIL wrap_17: gen4=%0d expected 1", gen4); end
        press(1'b1, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid_run;
        logic se;
        speed = 4'd0;
        press(1'b1, 1'b0, 1'b0);
        do_tick(0, se);
        checks++;
        if (se !== 1'b1 || running !== 1'b1) begin
            errors++; $display("FAIL midrun_pre: step_en=%b running=%b expected 1 1", se, running);
        end
        btn_run = 1'b1;  // held through reset: must not count as a press afterwards
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({step_en, seed_load, running, halted, extinct, gen_count} !== 21'd0) begin
            errors++; $display("FAIL midrun_reset: got %b expected all zero",
                               {step_en, seed_load, running, halted, extinct, gen_count});
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (running !== 1'b0) begin errors++; $display("FAIL held_button: running=%b expected 0", running); end
        btn_run = 1'b0;
        repeat (2) @(negedge clk);
        exp_gen = 0;
        checks++;
        if (running !== 1'b0 || gen_count !== 16'(exp_gen)) begin
            errors++; $display("FAIL post_reset: running=%b gen=%0d expected 0 0", running, gen_count);
        end
    endtask

    task automatic test_invariants;
        repeat (2) @(negedge clk);
        checks++;
        if (overlap !== 0) begin errors++; $display("FAIL overlap: got %0d expected 0", overlap); end
        checks++;
        if (spacing_viol !== 0) begin errors++; $display("FAIL spacing: got %0d expected 0", spacing_viol); end
        checks++;
        if (mism4 !== 0) begin errors++; $display("FAIL gen4_instance: got %0d expected 0", mism4); end
    endtask

    initial begin
        pat_blinker = '0;
        pat_blinker[7 * W + 9]  = 1'b1;
        pat_blinker[7 * W + 10] = 1'b1;
        pat_blinker[7 * W + 11] = 1'b1;
        pat_block = '0;
        pat_block[3 * W + 3] = 1'b1;
        pat_block[3 * W + 4] = 1'b1;
        pat_block[4 * W + 3] = 1'b1;
        pat_block[4 * W + 4] = 1'b1;
        pat_single = '0;
        pat_single[10 * W + 15] = 1'b1;
        seed_pat = pat_blinker;

        test_reset;
        test_single_step;
        test_run_pacing;
        test_still_life;
        test_extinction;
        test_simultaneous;
        test_wrap;
        test_reset_mid_run;
        test_invariants;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
